// File: rtl/tron_player_ctrl.sv
// rtl/tron_player_ctrl.sv - Tron light-cycle player controller: heading, movement, bound check, plot handshake
module tron_player_ctrl #(
  parameter logic [7:0] START_X = 8'd21,
  parameter logic [6:0] START_Y = 7'd21,
  parameter logic [7:0] X_MIN   = 8'd21,
  parameter logic [7:0] X_MAX   = 8'd49,
  parameter logic [6:0] Y_MIN   = 7'd21,
  parameter logic [6:0] Y_MAX   = 7'd49,
  parameter logic [2:0] COLOR   = 3'b100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       plot_ready,
  output logic       plot_valid,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] color_out,
  output logic [1:0] dir,
  output logic       alive,
  output logic       crashed,
  output logic [7:0] moves
);

  typedef enum logic [2:0] {S_IDLE, S_DRAW, S_WAIT_TICK, S_MOVE, S_DEAD} state_t;

  state_t     r_state;
  logic [7:0] r_head_x;
  logic [6:0] r_head_y;
  logic [1:0] r_dir;
  logic [1:0] r_req_dir;
  logic       r_tick_pending;
  logic       r_plot_valid;
  logic       r_alive;
  logic       r_crashed;
  logic [7:0] r_moves;

  logic       w_btn_any;
  logic [1:0] w_btn_dir;
  logic       w_sample_dir;
  logic       w_reverse;
  logic [1:0] w_new_dir;
  logic [8:0] w_next_x;
  logic [7:0] w_next_y;
  logic       w_out_of_range;

  assign w_btn_any    = btn_up | btn_down | btn_left | btn_right;
  assign w_sample_dir = w_btn_any &&
                        (r_state == S_DRAW || r_state == S_WAIT_TICK || r_state == S_MOVE);

  always_comb begin
    w_btn_dir = 2'b00;
    if (btn_up)        w_btn_dir = 2'b11;
    else if (btn_down) w_btn_dir = 2'b01;
    else if (btn_left) w_btn_dir = 2'b10;
  end

  // Opposite headings differ only in bit 1 (00/10 and 01/11).
  assign w_reverse = ((r_req_dir ^ r_dir) == 2'b10);
  assign w_new_dir = w_reverse ? r_dir : r_req_dir;

  // One extra bit so stepping off either edge can never wrap back into range.
  always_comb begin
    w_next_x = {1'b0, r_head_x};
    w_next_y = {1'b0, r_head_y};
    case (w_new_dir)
      2'b00:   w_next_x = {1'b0, r_head_x} + 9'd1;
      2'b01:   w_next_y = {1'b0, r_head_y} + 8'd1;
      2'b10:   w_next_x = {1'b0, r_head_x} - 9'd1;
      default: w_next_y = {1'b0, r_head_y} - 8'd1;
    endcase
  end

  assign w_out_of_range = (w_next_x < {1'b0, X_MIN}) || (w_next_x > {1'b0, X_MAX}) ||
                          (w_next_y < {1'b0, Y_MIN}) || (w_next_y > {1'b0, Y_MAX});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_head_x       <= START_X;
      r_head_y       <= START_Y;
      r_dir          <= 2'b00;
      r_req_dir      <= 2'b00;
      r_tick_pending <= 1'b0;
      r_plot_valid   <= 1'b0;
      r_alive        <= 1'b0;
      r_crashed      <= 1'b0;
      r_moves        <= 8'd0;
    end else begin
      if (w_sample_dir) r_req_dir <= w_btn_dir;
      case (r_state)
        S_IDLE, S_DEAD: begin
          if (go) begin
            r_state        <= S_DRAW;
            r_head_x       <= START_X;
            r_head_y       <= START_Y;
            r_dir          <= 2'b00;
            r_req_dir      <= 2'b00;
            r_tick_pending <= 1'b0;
            r_moves        <= 8'd0;
            r_crashed      <= 1'b0;
            r_alive        <= 1'b1;
            r_plot_valid   <= 1'b1;
          end
        end
        S_DRAW: begin
          if (tick) r_tick_pending <= 1'b1;
          if (plot_ready) begin
            r_state      <= S_WAIT_TICK;
            r_plot_valid <= 1'b0;
          end
        end
        S_WAIT_TICK: begin
          if (tick || r_tick_pending) begin
            r_tick_pending <= 1'b0;
            r_state        <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (tick) r_tick_pending <= 1'b1;
          r_dir <= w_new_dir;
          if (w_out_of_range) begin
            r_crashed <= 1'b1;
            r_alive   <= 1'b0;
            r_state   <= S_DEAD;
          end else begin
            r_head_x     <= w_next_x[7:0];
            r_head_y     <= w_next_y[6:0];
            if (r_moves != 8'hFF) r_moves <= r_moves + 8'd1;
            r_plot_valid <= 1'b1;
            r_state      <= S_DRAW;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign plot_valid = r_plot_valid;
  assign x_out      = r_head_x;
  assign y_out      = r_head_y;
  assign color_out  = COLOR;
  assign dir        = r_dir;
  assign alive      = r_alive;
  assign crashed    = r_crashed;
  assign moves      = r_moves;

endmodule

// File: tb/tb_tron_player_ctrl.sv
// tb/tb_tron_player_ctrl.sv - directed self-checking bench for tron_player_ctrl
module tb_tron_player_ctrl;

  logic       clk = 1'b0;
  logic       resetn, go, tick, btn_up, btn_down, btn_left, btn_right, plot_ready;
  logic       plot_valid, alive, crashed;
  logic [7:0] x_out, moves;
  logic [6:0] y_out;
  logic [2:0] color_out;
  logic [1:0] dir;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [3:0] B_NONE = 4'b0000, B_UP = 4'b1000, B_DOWN = 4'b0100,
                         B_LEFT = 4'b0010, B_RIGHT = 4'b0001;

  tron_player_ctrl dut (
    .clk(clk), .resetn(resetn), .go(go), .tick(tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .plot_ready(plot_ready), .plot_valid(plot_valid), .x_out(x_out), .y_out(y_out),
    .color_out(color_out), .dir(dir), .alive(alive), .crashed(crashed), .moves(moves)
  );

  always #5 clk = ~clk;

  task automatic set_btn(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
  endtask

  task automatic do_reset();
    resetn = 1'b0; go = 1'b0; tick = 1'b0; plot_ready = 1'b1;
    set_btn(B_NONE);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // go pulse, one DRAW cycle accepted, leaves the FSM in WAIT_TICK
  task automatic start_game();
    plot_ready = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
  endtask

  // From WAIT_TICK: tick with buttons held; samples the cycle after MOVE
  task automatic do_move(input logic [3:0] b, output logic pv, output logic [7:0] ox,
                         output logic [6:0] oy);
    set_btn(b);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    pv = plot_valid; ox = x_out; oy = y_out;
    @(negedge clk);
    set_btn(B_NONE);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (plot_valid !== 1'b0) $display("FAIL reset_pv got %0d want 0", plot_valid); else n_pass++;
    n_total++; if (alive !== 1'b0) $display("FAIL reset_alive got %0d want 0", alive); else n_pass++;
    n_total++; if (crashed !== 1'b0) $display("FAIL reset_crashed got %0d want 0", crashed); else n_pass++;
    n_total++; if ({x_out, y_out} !== {8'd21, 7'd21}) $display("FAIL reset_head got (%0d,%0d) want (21,21)", x_out, y_out); else n_pass++;
    n_total++; if ({dir, moves, color_out} !== {2'b00, 8'd0, 3'b100}) $display("FAIL reset_misc got dir=%0d moves=%0d col=%0d want 0 0 4", dir, moves, color_out); else n_pass++;
  endtask

  task automatic test_idle_tick();
    do_reset();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    start_game();
    repeat (3) @(negedge clk);
    n_total++; if ({plot_valid, x_out, moves} !== {1'b0, 8'd21, 8'd0}) $display("FAIL idle_tick_dropped got pv=%0d x=%0d moves=%0d want 0 21 0", plot_valid, x_out, moves); else n_pass++;
  endtask

  task automatic test_basic();
    logic pv; logic [7:0] ox; logic [6:0] oy;
    do_reset();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n_total++; if ({plot_valid, x_out, y_out, color_out} !== {1'b1, 8'd21, 7'd21, 3'b100}) $display("FAIL basic_first_plot got pv=%0d (%0d,%0d) col=%0d want 1 (21,21) 4", plot_valid, x_out, y_out, color_out); else n_pass++;
    n_total++; if (alive !== 1'b1) $display("FAIL basic_alive got %0d want 1", alive); else n_pass++;
    @(negedge clk);
    n_total++; if (plot_valid !== 1'b0) $display("FAIL basic_one_cycle_plot got pv=%0d want 0", plot_valid); else n_pass++;
    do_move(B_NONE, pv, ox, oy);
    n_total++; if ({pv, ox, oy} !== {1'b1, 8'd22, 7'd21}) $display("FAIL basic_move got pv=%0d (%0d,%0d) want 1 (22,21)", pv, ox, oy); else n_pass++;
    n_total++; if (moves !== 8'd1) $display("FAIL basic_moves got %0d want 1", moves); else n_pass++;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    n_total++; if ({x_out, moves, plot_valid} !== {8'd22, 8'd1, 1'b0}) $display("FAIL basic_go_ignored got x=%0d moves=%0d pv=%0d want 22 1 0", x_out, moves, plot_valid); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    plot_ready = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++; if ({plot_valid, x_out, y_out} !== {1'b1, 8'd21, 7'd21}) $display("FAIL stall_hold[%0d] got pv=%0d (%0d,%0d) want 1 (21,21)", i, plot_valid, x_out, y_out); else n_pass++;
      tick = (i == 2);
      @(negedge clk);
      tick = 1'b0;
    end
    plot_ready = 1'b1;
    @(negedge clk);
    n_total++; if (plot_valid !== 1'b0) $display("FAIL stall_release got pv=%0d want 0", plot_valid); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if ({plot_valid, x_out, moves} !== {1'b1, 8'd22, 8'd1}) $display("FAIL stall_pending_move got pv=%0d x=%0d moves=%0d want 1 22 1", plot_valid, x_out, moves); else n_pass++;
  endtask

  task automatic test_reversal();
    logic pv; logic [7:0] ox; logic [6:0] oy;
    do_reset();
    start_game();
    do_move(B_DOWN, pv, ox, oy);
    n_total++; if ({ox, oy, dir} !== {8'd21, 7'd22, 2'b01}) $display("FAIL rev_down got (%0d,%0d) dir=%0d want (21,22) 1", ox, oy, dir); else n_pass++;
    do_move(B_RIGHT, pv, ox, oy);
    do_move(B_LEFT, pv, ox, oy);
    n_total++; if ({ox, oy, dir} !== {8'd23, 7'd22, 2'b00}) $display("FAIL rev_ignored got (%0d,%0d) dir=%0d want (23,22) 0", ox, oy, dir); else n_pass++;
    do_move(B_UP | B_LEFT, pv, ox, oy);
    n_total++; if ({ox, oy, dir} !== {8'd23, 7'd21, 2'b11}) $display("FAIL rev_up_priority got (%0d,%0d) dir=%0d want (23,21) 3", ox, oy, dir); else n_pass++;
  endtask

  task automatic test_crash();
    logic pv; logic [7:0] ox; logic [6:0] oy;
    do_reset();
    start_game();
    for (int k = 0; k < 9; k++) do_move(B_DOWN, pv, ox, oy);
    for (int k = 0; k < 28; k++) do_move(B_RIGHT, pv, ox, oy);
    n_total++; if ({ox, oy, dir} !== {8'd49, 7'd30, 2'b00}) $display("FAIL crash_setup got (%0d,%0d) dir=%0d want (49,30) 0", ox, oy, dir); else n_pass++;
    do_move(B_NONE, pv, ox, oy);
    n_total++; if ({pv, crashed, alive} !== 3'b010) $display("FAIL crash_flags got pv=%0d crashed=%0d alive=%0d want 0 1 0", pv, crashed, alive); else n_pass++;
    n_total++; if ({x_out, y_out, moves} !== {8'd49, 7'd30, 8'd37}) $display("FAIL crash_hold got (%0d,%0d) moves=%0d want (49,30) 37", x_out, y_out, moves); else n_pass++;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if ({plot_valid, crashed, x_out} !== {1'b0, 1'b1, 8'd49}) $display("FAIL crash_dead_stays got pv=%0d crashed=%0d x=%0d want 0 1 49", plot_valid, crashed, x_out); else n_pass++;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n_total++; if ({plot_valid, x_out, y_out, crashed, moves, alive} !== {1'b1, 8'd21, 7'd21, 1'b0, 8'd0, 1'b1}) $display("FAIL crash_restart got pv=%0d (%0d,%0d) crashed=%0d moves=%0d alive=%0d want 1 (21,21) 0 0 1", plot_valid, x_out, y_out, crashed, moves, alive); else n_pass++;
  endtask

  task automatic test_low_bound();
    logic pv; logic [7:0] ox; logic [6:0] oy;
    do_reset();
    start_game();
    do_move(B_UP, pv, ox, oy);
    n_total++; if ({pv, crashed, y_out, dir} !== {1'b0, 1'b1, 7'd21, 2'b11}) $display("FAIL low_bound got pv=%0d crashed=%0d y=%0d dir=%0d want 0 1 21 3", pv, crashed, y_out, dir); else n_pass++;
  endtask

  task automatic test_saturate();
    logic pv; logic [7:0] ox; logic [6:0] oy;
    logic [3:0] seq [4];
    seq[0] = B_RIGHT; seq[1] = B_DOWN; seq[2] = B_LEFT; seq[3] = B_UP;
    do_reset();
    start_game();
    for (int l = 0; l < 3; l++) begin
      for (int d = 0; d < 4; d++)
        for (int k = 0; k < 28; k++) do_move(seq[d], pv, ox, oy);
      if (l == 0) begin
        n_total++; if ({ox, oy, moves} !== {8'd21, 7'd21, 8'd112}) $display("FAIL sat_loop1 got (%0d,%0d) moves=%0d want (21,21) 112", ox, oy, moves); else n_pass++;
      end
    end
    n_total++; if ({moves, alive, crashed} !== {8'd255, 1'b1, 1'b0}) $display("FAIL sat_moves got moves=%0d alive=%0d crashed=%0d want 255 1 0", moves, alive, crashed); else n_pass++;
  endtask

  task automatic test_reset_mid_draw();
    logic pv; logic [7:0] ox; logic [6:0] oy;
    do_reset();
    start_game();
    do_move(B_DOWN, pv, ox, oy);
    plot_ready = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    n_total++; if ({plot_valid, y_out} !== {1'b1, 7'd23}) $display("FAIL mid_draw_setup got pv=%0d y=%0d want 1 23", plot_valid, y_out); else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_total++; if ({plot_valid, alive, crashed} !== 3'b000) $display("FAIL mid_draw_async got pv=%0d alive=%0d crashed=%0d want 0 0 0", plot_valid, alive, crashed); else n_pass++;
    n_total++; if ({x_out, y_out, dir, moves, color_out} !== {8'd21, 7'd21, 2'b00, 8'd0, 3'b100}) $display("FAIL mid_draw_values got (%0d,%0d) dir=%0d moves=%0d col=%0d want (21,21) 0 0 4", x_out, y_out, dir, moves, color_out); else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n_total++; if ({plot_valid, alive} !== 2'b11) $display("FAIL first_go_after_reset got pv=%0d alive=%0d want 1 1", plot_valid, alive); else n_pass++;
  endtask

  initial begin
    resetn = 1'b0; go = 1'b0; tick = 1'b0; plot_ready = 1'b0;
    set_btn(B_NONE);
    test_reset();
    test_idle_tick();
    test_basic();
    test_stall();
    test_reversal();
    test_crash();
    test_low_bound();
    test_saturate();
    test_reset_mid_draw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tron_player_ctrl.md
TRON_PLAYER_CTRL -- requirements
Module: tron_player_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 START_X, 8'd21, head x after start
 START_Y, 7'd21, head y after start
 X_MIN / X_MAX, 8'd21 / 8'd49, legal x range, inclusive
 Y_MIN / Y_MAX, 7'd21 / 7'd49, legal y range, inclusive
 COLOR, 3'b100, trail colour
REQ-002 Ports (name, direction, width, meaning), one per line:
 clk  in  1  system clock, all state on rising edge
 resetn  in  1  asynchronous, active-low reset
 go  in  1  start/restart request, one-cycle pulse
 tick  in  1  movement enable pulse, one step per tick
 btn_up, btn_down, btn_left, btn_right  in  1 each  direction requests, level, active-high
 plot_ready  in  1  downstream drawer accepts the current plot
 plot_valid  out  1  plot request valid
 x_out  out  8  plot x
 y_out  out  7  plot y
 color_out  out  3  plot colour
 dir  out  2  current heading: 00 right, 01 down, 10 left, 11 up
 alive  out  1  game running
 crashed  out  1  head left the legal range
 moves  out  8  steps taken since start, saturating

Function
REQ-003 FSM states: IDLE, DRAW, WAIT_TICK, MOVE, DEAD.
REQ-004 IDLE: plot_valid=0, alive=0; on go, load head=(START_X,START_Y), dir=00, moves=0, crashed=0; next state DRAW.
REQ-005 DRAW: plot_valid=1, x_out/y_out = head, color_out=COLOR; all three held stable until a cycle with plot_ready=1; that cycle completes the transfer; next state WAIT_TICK.
REQ-006 plot_valid SHALL NOT drop before plot_ready is seen; no plot_valid outside DRAW.
REQ-007 WAIT_TICK: on tick, or with tick_pending set, go to MOVE the next cycle and clear tick_pending.
REQ-008 tick asserted in DRAW or MOVE sets a one-deep tick_pending flag; further ticks coalesce; ticks in IDLE/DEAD are dropped.
REQ-009 Direction request is sampled every cycle in DRAW, WAIT_TICK and MOVE into req_dir; priority up > down > left > right; no button leaves req_dir unchanged.
REQ-010 A req_dir that reverses dir (right<->left, up<->down) SHALL be discarded; the comparison is against dir as last committed in MOVE.
REQ-011 MOVE (one cycle): dir <= req_dir; next head = head +/-1 on one axis per the new dir; if next head is outside [X_MIN..X_MAX]x[Y_MIN..Y_MAX], head is unchanged, crashed<=1, next state DEAD; otherwise head <= next head, moves <= moves+1 saturating at 255, next state DRAW.
REQ-012 Bound check SHALL use widened arithmetic: x=0 minus 1 is out of range, never a wrap to 255.
REQ-013 DEAD: alive=0, crashed=1, plot_valid=0, head/dir/moves hold; go behaves as in IDLE (REQ-004).
REQ-014 alive=1 in DRAW, WAIT_TICK, MOVE.
REQ-015 go in DRAW/WAIT_TICK/MOVE is ignored.
REQ-016 Latency: tick accepted in WAIT_TICK -> plot_valid for the new head 2 cycles later.

Reset
REQ-017 resetn=0 asynchronously forces: state=IDLE, plot_valid=0, alive=0, crashed=0, dir=00, moves=0, head=(START_X,START_Y), req_dir=00, tick_pending=0, x_out/y_out = head, color_out=COLOR.
REQ-018 Reset mid-DRAW SHALL drop plot_valid immediately, with no handshake completion.
REQ-019 Deassertion is synchronous to clk; the first go is honoured on the first rising edge after deassertion.

Verification
REQ-020 Reset, go, plot_ready=1 -> plot (21,21,100) in one cycle; tick -> plot (22,21), moves=1.
REQ-021 plot_ready=0 for 5 cycles in DRAW with a tick pulse -> plot_valid and (x,y) stable for 5 cycles; after ready, MOVE with no further tick, next plot at x+1.
REQ-022 dir=right, btn_left held, tick -> move to x+1 (reversal ignored); btn_up+btn_left, tick -> dir=11, y-1.
REQ-023 Head (49,30), dir right, tick -> crashed=1, alive=0, state DEAD, no plot; go -> plot (21,21), crashed=0, moves=0.
REQ-024 300 successful moves in a loop -> moves=255.
REQ-025 resetn low while plot_valid=1 -> plot_valid=0 in the same cycle, all outputs at REQ-017 values.
